axil_mtimer: RTL



---
 rtl/mtimer_pkg.sv | 42 ++++
 rtl/axil_mtimer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_pkg.sv
// ============================================================================
// Module   : mtimer_pkg
// Purpose  : Register offsets, response codes and FSM state types for the
//            AXI-lite RISC-V machine timer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mtimer_pkg;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PRESCALE    = 5'h14;
    localparam logic [4:0] OFF_LIMIT       = 5'h18;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Unaligned offsets and anything past PRESCALE are rejected with SLVERR.
    function automatic logic addr_err(input logic [4:0] off);
        return (off[1:0] != 2'b00) || (off >= OFF_LIMIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_mtimer.sv
// ============================================================================
// Module   : axil_mtimer
// Purpose  : AXI-lite RISC-V machine timer: prescaled 64-bit mtime, mtimecmp
//            and a registered level timer interrupt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axil_mtimer
    import mtimer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic        s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [3:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        timer_irq
);

    localparam logic [PRESCALE_W-1:0] c_ps_one = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    wr_state_t              wr_state_q, wr_state_d;
    rd_state_t              rd_state_q, rd_state_d;
    logic [4:0]             awaddr_q, awaddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [3:0]             rresp_q, rresp_d;

    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic                   en_q, en_d;
    logic                   irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
    logic [PRESCALE_W-1:0]  ps_cnt_q, ps_cnt_d;
    logic [31:0]            hi_shadow_q, hi_shadow_d;
    logic                   irq_q, irq_d;

    logic                   w_aw_hs, w_w_hs, w_ar_hs;
    logic                   w_wr_commit, w_wr_ok;
    logic [4:0]             w_wr_addr;
    logic [31:0]            w_wr_data;
    logic [4:0]             w_rd_off;
    logic [31:0]            w_rd_mux;
    logic [31:0]            w_ps_ext;
    logic                   w_rd_snap;
    logic                   w_tick;
    logic                   w_unused_bits;

    assign w_unused_bits = ^{s_axi_awaddr[31:5], s_axi_araddr[31:5],
                             s_axi_awprot, s_axi_arprot, s_axi_wstrb};

    assign s_axi_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_GOT_W);
    assign s_axi_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_GOT_AW);
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (rd_state_q == R_IDLE);
    assign s_axi_rvalid  = (rd_state_q == R_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign timer_irq     = irq_q;

    assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
    assign w_rd_off = s_axi_araddr[4:0];
    assign w_wr_ok  = w_wr_commit && !addr_err(w_wr_addr);

    // ---------------- write channel ----------------
    always_comb begin
        wr_state_d  = wr_state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        bresp_d     = bresp_q;
        w_wr_commit = 1'b0;
        w_wr_addr   = awaddr_q;
        w_wr_data   = wdata_q;
        case (wr_state_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wr_commit = 1'b1;
                    w_wr_addr   = s_axi_awaddr[4:0];
                    w_wr_data   = s_axi_wdata;
                    wr_state_d  = W_RESP;
                end else if (w_aw_hs) begin
                    awaddr_d   = s_axi_awaddr[4:0];
                    wr_state_d = W_GOT_AW;
                end else if (w_w_hs) begin
                    wdata_d    = s_axi_wdata;
                    wr_state_d = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_w_hs) begin
                    w_wr_commit = 1'b1;
                    w_wr_data   = s_axi_wdata;
                    wr_state_d  = W_RESP;
                end
            end
            W_GOT_W: begin
                if (w_aw_hs) begin
                    w_wr_commit = 1'b1;
                    w_wr_addr   = s_axi_awaddr[4:0];
                    wr_state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (w_wr_commit) begin
            bresp_d = addr_err(w_wr_addr) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        w_ps_ext = '0;
        w_ps_ext[PRESCALE_W-1:0] = prescale_q;
        w_rd_mux = '0;
        case (w_rd_off)
            OFF_MTIME_LO:    w_rd_mux = mtime_q[31:0];
            OFF_MTIME_HI:    w_rd_mux = hi_shadow_q;
            OFF_MTIMECMP_LO: w_rd_mux = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: w_rd_mux = mtimecmp_q[63:32];
            OFF_CTRL:        w_rd_mux = {30'd0, irq_en_q, en_q};
            OFF_PRESCALE:    w_rd_mux = w_ps_ext;
            default:         w_rd_mux = '0;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rd_state_d = R_RESP;
                    if (addr_err(w_rd_off)) begin
                        rdata_d = '0;
                        rresp_d = {2'b00, RESP_SLVERR};
                    end else begin
                        rdata_d = w_rd_mux;
                        rresp_d = {2'b00, RESP_OKAY};
                    end
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // ---------------- timer core ----------------
    assign w_tick    = en_q && (ps_cnt_q == prescale_q);
    assign w_rd_snap = w_ar_hs && (w_rd_off == OFF_MTIME_LO);

    // Writes are applied after the tick so a same-cycle mtime write drops that tick.
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        prescale_d  = prescale_q;
        ps_cnt_d    = ps_cnt_q;
        hi_shadow_d = hi_shadow_q;
        if (en_q) begin
            if (w_tick) begin
                mtime_d  = mtime_q + 64'd1;
                ps_cnt_d = '0;
            end else begin
                ps_cnt_d = ps_cnt_q + c_ps_one;
            end
        end
        if (w_rd_snap) begin
            hi_shadow_d = mtime_q[63:32];
        end
        if (w_wr_ok) begin
            case (w_wr_addr)
                OFF_MTIME_LO:    mtime_d    = {mtime_q[63:32], w_wr_data};
                OFF_MTIME_HI:    mtime_d    = {w_wr_data, mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], w_wr_data};
                OFF_MTIMECMP_HI: mtimecmp_d = {w_wr_data, mtimecmp_q[31:0]};
                OFF_CTRL: begin
                    en_d     = w_wr_data[0];
                    irq_en_d = w_wr_data[1];
                    ps_cnt_d = '0;
                end
                OFF_PRESCALE: begin
                    prescale_d = w_wr_data[PRESCALE_W-1:0];
                    ps_cnt_d   = '0;
                end
                default: ;
            endcase
        end
        irq_d = irq_en_q && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            prescale_q  <= '0;
            ps_cnt_q    <= '0;
            hi_shadow_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            prescale_q  <= prescale_d;
            ps_cnt_q    <= ps_cnt_d;
            hi_shadow_q <= hi_shadow_d;
            irq_q       <= irq_d;
        end
    end

endmodule

`default_nettype wire
